// File: rtl/game_countdown_timer.sv
// Purpose: two-digit BCD level countdown, one step per tick edge; timeout pulse on expiry. Optional macro: TIMER_WARN_BLINK_EN.
// Latency: start/tick effects visible one cycle after the sampling edge; all outputs registered.
// Backpressure: none; ticks arriving while paused or expired are dropped, not queued.
module game_countdown_timer #(
  parameter logic [7:0] DEFAULT_SECS = 8'h60,
  parameter logic [7:0] WARN_SECS    = 8'h10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       duty50_in,
  input  logic       start,
  input  logic       pause,
  input  logic [7:0] load_val,
  output logic [3:0] ones,
  output logic [3:0] tens,
  output logic       running,
  output logic       expired,
  output logic       timeout,
  output logic       warning
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSED, S_EXPIRED} state_t;

  state_t     state;
  state_t     nxt_state;
  logic [7:0] nxt_digits;
  logic       nxt_timeout;
  logic       tick_d;
  logic       tick_rise;
  logic       load_ok;
  logic       low_time;
  logic       warn_nxt;

  // Edge detect on tick and BCD validity of the requested start value.
  always_comb begin
    tick_rise = tick & ~tick_d;
    load_ok   = (load_val[7:4] <= 4'd9) && (load_val[3:0] <= 4'd9) && (load_val != 8'h00);
  end

  // Next state and digits; start outranks pause, which outranks the tick edge.
  always_comb begin
    nxt_state   = state;
    nxt_digits  = {tens, ones};
    nxt_timeout = 1'b0;
    if (start) begin
      nxt_state  = S_RUN;
      nxt_digits = load_ok ? load_val : DEFAULT_SECS;
    end else begin
      case (state)
        S_RUN: begin
          if (pause) begin
            nxt_state = S_PAUSED;
          end else if (tick_rise) begin
            // Treat anything at or below 01 as the last step so the count can never wrap.
            if ({tens, ones} <= 8'h01) begin
              nxt_digits  = 8'h00;
              nxt_state   = S_EXPIRED;
              nxt_timeout = 1'b1;
            end else if (ones == 4'd0) begin
              nxt_digits = {tens - 4'd1, 4'd9};
            end else begin
              nxt_digits = {tens, ones - 4'd1};
            end
          end
        end
        S_PAUSED: begin
          if (!pause) nxt_state = S_RUN;
        end
        default: begin
        end
      endcase
    end
  end

  // Low-time indication is derived from the next state so it lines up with the digits it describes.
  always_comb begin
    low_time = ((nxt_state == S_RUN) || (nxt_state == S_PAUSED)) && (nxt_digits <= WARN_SECS);
`ifdef TIMER_WARN_BLINK_EN
    warn_nxt = low_time & duty50_in;
`else
    warn_nxt = low_time;
`endif
  end

`ifndef TIMER_WARN_BLINK_EN
  // The blink source is only consumed by the blinking variant.
  logic unused_duty;
  assign unused_duty = duty50_in;
`endif

  // State, digits and every output flag are registered together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      tens    <= DEFAULT_SECS[7:4];
      ones    <= DEFAULT_SECS[3:0];
      tick_d  <= 1'b0;
      running <= 1'b0;
      expired <= 1'b0;
      timeout <= 1'b0;
      warning <= 1'b0;
    end else begin
      state   <= nxt_state;
      tens    <= nxt_digits[7:4];
      ones    <= nxt_digits[3:0];
      tick_d  <= tick;
      running <= (nxt_state == S_RUN);
      expired <= (nxt_state == S_EXPIRED);
      timeout <= nxt_timeout;
      warning <= warn_nxt;
    end
  end

endmodule

// File: doc/game_countdown_timer.md
Name: game_countdown_timer

Overview:
- Downstream consumer of the one-second tick generator: counts a two-digit BCD level timer down to zero, one step per tick.
- Drives the score/timer seven-segment decoders.
- Raises a single-cycle timeout pulse for the game controller when the count expires.
- Supports start/reload, pause, and an optional low-time blink indication.

Parameters:
- DEFAULT_SECS, 8'h60, BCD seconds loaded at reset and when load_val is invalid or zero.
- WARN_SECS, 8'h10, BCD threshold; warning asserts while remaining <= WARN_SECS and state is RUN or PAUSED.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- tick  in  1  one-second pulse from the tick generator; may be multi-cycle high, so counting is edge-based
- duty50_in  in  1  slow 50%-duty square wave from the tick generator (blink source)
- start  in  1  load load_val and begin counting
- pause  in  1  level; counting suspended while high
- load_val  in  8  BCD start value {tens,ones}
- ones  out  4  BCD ones digit of remaining seconds
- tens  out  4  BCD tens digit of remaining seconds
- running  out  1  high in RUN
- expired  out  1  high in EXPIRED
- timeout  out  1  one-cycle pulse on entry to EXPIRED
- warning  out  1  low-time indicator (see Optional Feature)

Behaviour:
- States: IDLE, RUN, PAUSED, EXPIRED. All outputs are registered.
- Reset (asynchronous, any time, including mid-count):
  - state=IDLE, {tens,ones}=DEFAULT_SECS, tick_d=0.
  - running=0, expired=0, timeout=0, warning=0.
- Tick edge: tick_rise = tick & ~tick_d. tick_d is registered every cycle. A tick held high for N cycles counts once.
- Priority, highest first: reset > start > pause > tick_rise.
- start, any state:
  - Validity: load_val is valid if both nibbles <= 9 and the value != 8'h00.
  - Load {tens,ones}=load_val if valid, else DEFAULT_SECS.
  - state=RUN; tick_d<=tick, so a tick already high is not counted.
  - Visible the cycle after start is sampled.
- IDLE: digits hold; start is the only exit.
- RUN:
  - pause=1 -> PAUSED; a tick_rise in that cycle is discarded.
  - Else on tick_rise, if {tens,ones}==8'h01: digits=00, state=EXPIRED, timeout=1 for exactly one cycle (the same edge that enters EXPIRED).
  - Else BCD decrement: ones==0 -> ones=9, tens=tens-1; otherwise ones=ones-1.
  - Digit update is registered on the edge that samples tick high; it is visible one cycle later.
- PAUSED: digits frozen; tick_rise ignored; pause=0 -> RUN on the next edge, with no catch-up of missed ticks.
- EXPIRED:
  - Digits held at 00, expired=1, timeout=0 after the first cycle.
  - tick and pause are ignored; only start or reset exits.
- running=1 only in RUN. expired=1 only in EXPIRED.
- Digits never leave BCD range, never wrap below 00, and never exceed 99.
- Width: BCD nibbles only; comparisons with WARN_SECS are unsigned on the 8-bit {tens,ones} value, which is valid because both are BCD.

Optional Feature:
- Macro: TIMER_WARN_BLINK_EN.
- Defined: warning = duty50_in while the low-time condition holds (remaining <= WARN_SECS in RUN/PAUSED), sampled and registered, so it lags duty50_in by one cycle. Otherwise warning=0.
- Undefined: warning is a steady registered level equal to the low-time condition; duty50_in is unused.
- Both variants: warning=0 in IDLE and EXPIRED.

Test Plan:
- Reset, then start with load_val=8'h03; three tick pulses -> digits 03,02,01,00; timeout high exactly one cycle with the third tick; expired=1, running=0.
- load_val=8'h10; one tick -> digits 09 (ones borrow, tens 1->0). load_val=8'h1A (invalid) -> digits load 60.
- In RUN at 8'h25: assert pause, apply 3 ticks -> digits stay 25, running=0; deassert pause, 1 tick -> 24.
- tick held high 5 cycles in RUN -> exactly one decrement. tick and start in the same cycle -> load wins, no decrement. reset asserted mid-count at 8'h37 -> next cycle IDLE, digits 60, all flags 0.
- Warning, with WARN_SECS=8'h10, counting from 8'h12:
  - Without the macro: warning rises when digits reach 10 and stays high through 01; it is 0 in EXPIRED.
  - With TIMER_WARN_BLINK_EN: warning follows duty50_in delayed one cycle while digits <= 10.
